// File: rtl/udp_ip_encoder_if.sv
// udp_ip_encoder_if: header fields, payload source handshake and packet
// output of the UDP/IPv4 encoder. The master side drives the datagram
// request and payload; the slave side is the encoder.
// Optional macro UDP_CHECKSUM_EN adds the payload_sum input.
interface udp_ip_encoder_if;
    // Datagram request and header fields
    logic        start;
    logic [15:0] len_data;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [15:0] identification;
    logic [7:0]  type_of_ser;
    logic [7:0]  time_to_live;
`ifdef UDP_CHECKSUM_EN
    logic [15:0] payload_sum;
`endif
    // Payload source (first-word-fall-through)
    logic [31:0] data_in;
    logic        empty;
    logic        rd_en;
    // Packet output and status
    logic [31:0] data_out;
    logic        wr_en;
    logic        busy;
    logic        fin;
    logic        err;

    modport master (
        output start, len_data, src_ip, dest_ip, src_port, dest_port,
               identification, type_of_ser, time_to_live, data_in, empty,
        input  rd_en, data_out, wr_en, busy, fin, err
`ifdef UDP_CHECKSUM_EN
        , output payload_sum
`endif
    );

    modport slave (
        input  start, len_data, src_ip, dest_ip, src_port, dest_port,
               identification, type_of_ser, time_to_live, data_in, empty,
        output rd_en, data_out, wr_en, busy, fin, err
`ifdef UDP_CHECKSUM_EN
        , input payload_sum
`endif
    );
endinterface

// File: rtl/udp_ip_encoder.sv
// udp_ip_encoder: builds an IPv4 + UDP header (7 words) followed by the
// payload words pulled from a FWFT source, one 32-bit word per cycle.
// Optional macro UDP_CHECKSUM_EN computes the UDP checksum from the
// pseudo-header, UDP header and a caller-supplied payload_sum; without it
// the UDP checksum field is sent as zero.
module udp_ip_encoder (
    input  logic               clk,
    input  logic               reset,
    udp_ip_encoder_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, CSUM, HDR, DATA, DONE} state_t;

    // Largest payload that still fits in a 65535-byte IP datagram.
    localparam logic [15:0] MAX_LEN = 16'd65507;

    state_t      state_q;
    logic [15:0] len_q;
    logic [31:0] src_ip_q;
    logic [31:0] dest_ip_q;
    logic [15:0] src_port_q;
    logic [15:0] dest_port_q;
    logic [15:0] id_q;
    logic [7:0]  tos_q;
    logic [7:0]  ttl_q;
`ifdef UDP_CHECKSUM_EN
    logic [15:0] psum_q;
`endif
    logic [15:0] ip_csum_q;
    logic [15:0] udp_csum_q;
    logic [2:0]  hdr_cnt_q;
    logic [15:0] words_left_q;
    logic [31:0] data_out_q;
    logic        wr_en_q;
    logic        rd_en_q;
    logic        busy_q;
    logic        fin_q;
    logic        err_q;

    logic [15:0] total_len;
    logic [15:0] udp_len;
    logic [19:0] ip_sum;
    logic [15:0] ip_csum_d;
    logic [15:0] udp_csum_d;
    logic [31:0] hdr_word_d;
    logic [31:0] lane_mask;

    // Zero-extend a halfword so ten of them can be summed without overflow.
    function automatic logic [19:0] ext(input logic [15:0] h);
        return {4'h0, h};
    endfunction

    // End-around carry fold; two passes always leave a 16-bit value.
    function automatic logic [15:0] fold(input logic [19:0] s);
        logic [16:0] t;
        t = {1'b0, s[15:0]} + {13'h0, s[19:16]};
        return t[15:0] + {15'h0, t[16]};
    endfunction

    // Header arithmetic, header word selection and last-word byte masking
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        total_len  = len_q + 16'd28;
        udp_len    = len_q + 16'd8;
        ip_sum     = ext({4'h4, 4'h5, tos_q}) + ext(total_len) + ext(id_q)
                   + ext(16'h4000) + ext({ttl_q, 8'h11})
                   + ext(src_ip_q[31:16]) + ext(src_ip_q[15:0])
                   + ext(dest_ip_q[31:16]) + ext(dest_ip_q[15:0]);
        ip_csum_d  = ~fold(ip_sum);
        udp_csum_d = 16'h0000;
`ifdef UDP_CHECKSUM_EN
        udp_csum_d = ~fold(ext(src_ip_q[31:16]) + ext(src_ip_q[15:0])
                         + ext(dest_ip_q[31:16]) + ext(dest_ip_q[15:0])
                         + ext(16'h0011) + ext(udp_len)
                         + ext(src_port_q) + ext(dest_port_q)
                         + ext(udp_len) + ext(psum_q));
        if (udp_csum_d == 16'h0000)
            udp_csum_d = 16'hFFFF;
`endif
        case (hdr_cnt_q)
            3'd1:    hdr_word_d = {id_q, 3'b010, 13'd0};
            3'd2:    hdr_word_d = {ttl_q, 8'h11, ip_csum_q};
            3'd3:    hdr_word_d = src_ip_q;
            3'd4:    hdr_word_d = dest_ip_q;
            3'd5:    hdr_word_d = {src_port_q, dest_port_q};
            3'd6:    hdr_word_d = {udp_len, udp_csum_q};
            default: hdr_word_d = {4'h4, 4'h5, tos_q, total_len};
        endcase
        lane_mask = 32'hFFFF_FFFF;
        if (words_left_q == 16'd1) begin
            case (len_q[1:0])
                2'd1:    lane_mask = 32'hFF00_0000;
                2'd2:    lane_mask = 32'hFFFF_0000;
                2'd3:    lane_mask = 32'hFFFF_FF00;
                default: lane_mask = 32'hFFFF_FFFF;
            endcase
        end
    end

    // Packet sequencer; all outputs are registered here. Outputs become
    // visible one cycle after the state that produces them.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            state_q      <= IDLE;
            len_q        <= '0;
            src_ip_q     <= '0;
            dest_ip_q    <= '0;
            src_port_q   <= '0;
            dest_port_q  <= '0;
            id_q         <= '0;
            tos_q        <= '0;
            ttl_q        <= '0;
`ifdef UDP_CHECKSUM_EN
            psum_q       <= '0;
`endif
            ip_csum_q    <= '0;
            udp_csum_q   <= '0;
            hdr_cnt_q    <= '0;
            words_left_q <= '0;
            data_out_q   <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            fin_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    // busy_q is still high in the cycle fin is shown; a start
                    // seen then belongs to the finished packet and is dropped.
                    if (bus.start && !busy_q) begin
                        if (bus.len_data > MAX_LEN) begin
                            err_q <= 1'b1;
                        end else begin
                            len_q        <= bus.len_data;
                            src_ip_q     <= bus.src_ip;
                            dest_ip_q    <= bus.dest_ip;
                            src_port_q   <= bus.src_port;
                            dest_port_q  <= bus.dest_port;
                            id_q         <= bus.identification;
                            tos_q        <= bus.type_of_ser;
                            ttl_q        <= bus.time_to_live;
`ifdef UDP_CHECKSUM_EN
                            psum_q       <= bus.payload_sum;
`endif
                            words_left_q <= {2'b00, bus.len_data[15:2]}
                                          + {15'h0, |bus.len_data[1:0]};
                            busy_q       <= 1'b1;
                            state_q      <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    ip_csum_q  <= ip_csum_d;
                    udp_csum_q <= udp_csum_d;
                    data_out_q <= hdr_word_d;
                    wr_en_q    <= 1'b1;
                    hdr_cnt_q  <= 3'd1;
                    state_q    <= HDR;
                end
                HDR: begin
                    data_out_q <= hdr_word_d;
                    wr_en_q    <= 1'b1;
                    hdr_cnt_q  <= hdr_cnt_q + 3'd1;
                    if (hdr_cnt_q == 3'd6)
                        state_q <= (words_left_q == 16'd0) ? DONE : DATA;
                end
                DATA: begin
                    if (!bus.empty) begin
                        data_out_q   <= bus.data_in & lane_mask;
                        wr_en_q      <= 1'b1;
                        rd_en_q      <= 1'b1;
                        words_left_q <= words_left_q - 16'd1;
                        if (words_left_q == 16'd1)
                            state_q <= DONE;
                    end
                end
                DONE: begin
                    fin_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.busy     = busy_q;
    assign bus.fin      = fin_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_udp_ip_encoder.sv
// tb_udp_ip_encoder: scoreboard bench for udp_ip_encoder. Expected packet
// words are computed from the header fields and payload when a datagram is
// started, queued, and compared as the encoder writes them out.
module tb_udp_ip_encoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    udp_ip_encoder_if bus ();
    udp_ip_encoder dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cap[$];
    logic [31:0] pay[$];
    int          wr_cnt, cyc, last_wr_cyc, fin_cyc;
    bit          fin_seen;
    int          src_idx, stall_cnt;
    bit          stall_mode;

    logic [7:0]  f_tos, f_ttl;
    logic [15:0] f_id, f_sport, f_dport, f_psum;
    logic [31:0] f_sip, f_dip;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] fold_ref(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        while (t[31:16] != 16'h0)
            t = {16'h0, t[15:0]} + {16'h0, t[31:16]};
        return t[15:0];
    endfunction

    function automatic logic [15:0] ip_csum_ref(input logic [15:0] len);
        logic [15:0] hw[10];
        logic [31:0] s;
        hw = '{{8'h45, f_tos}, len + 16'd28, f_id, 16'h4000, {f_ttl, 8'h11},
               16'h0000, f_sip[31:16], f_sip[15:0], f_dip[31:16], f_dip[15:0]};
        s = 0;
        foreach (hw[i]) s += {16'h0, hw[i]};
        return ~fold_ref(s);
    endfunction

    // Sum of everything in the UDP checksum except payload_sum.
    function automatic logic [15:0] udp_fixed_sum(input logic [15:0] len);
        logic [31:0] s;
        s = {16'h0, f_sip[31:16]} + {16'h0, f_sip[15:0]} + {16'h0, f_dip[31:16]}
          + {16'h0, f_dip[15:0]} + 32'h11 + 2 * {16'h0, len + 16'd8}
          + {16'h0, f_sport} + {16'h0, f_dport};
        return fold_ref(s);
    endfunction

    // Payload source: advances on each consumed word, optional 3-cycle gap.
    always @(negedge clk) begin
        if (bus.rd_en) begin
            src_idx++;
            if (stall_mode) stall_cnt = 3;
        end else if (stall_cnt > 0) begin
            stall_cnt--;
        end
        bus.data_in = (src_idx < pay.size()) ? pay[src_idx] : 32'hDEAD_BEEF;
        bus.empty   = (src_idx >= pay.size()) || (stall_cnt > 0);
    end

    // Output monitor and scoreboard comparison.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (exp_q.size() == 0) check("spurious_wr", {31'h0, bus.wr_en}, 32'h0);
            else check($sformatf("word%0d", wr_cnt), bus.data_out, exp_q.pop_front());
            if (wr_cnt >= 7) check("rd_data", {31'h0, bus.rd_en}, 32'h1);
            else             check("rd_hdr", {31'h0, bus.rd_en}, 32'h0);
            cap.push_back(bus.data_out);
            wr_cnt++;
            last_wr_cyc = cyc;
        end else begin
            check("rd_idle", {31'h0, bus.rd_en}, 32'h0);
        end
        if (bus.fin) begin
            fin_seen = 1'b1;
            fin_cyc  = cyc;
        end
        cyc++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_fields();
        f_tos   = 8'($urandom);
        f_ttl   = 8'($urandom);
        f_id    = 16'($urandom);
        f_sport = 16'($urandom);
        f_dport = 16'($urandom);
        f_sip   = $urandom;
        f_dip   = $urandom;
    endtask

    // Build payload and expected words, then pulse start and check latency.
    task automatic begin_packet(input int len, input bit stall, input bit force_ffff);
        int          nw;
        logic [31:0] e, psum;
        logic [15:0] ul, uc;
        nw = (len + 3) / 4;
        pay.delete();
        for (int w = 0; w < nw; w++) pay.push_back($urandom);
        src_idx = 0; stall_cnt = 0; stall_mode = stall;
        ul = 16'(len) + 16'd8;
        exp_q.push_back({8'h45, f_tos, 16'(len) + 16'd28});
        exp_q.push_back({f_id, 16'h4000});
        exp_q.push_back({f_ttl, 8'h11, ip_csum_ref(16'(len))});
        exp_q.push_back(f_sip);
        exp_q.push_back(f_dip);
        exp_q.push_back({f_sport, f_dport});
        psum = 0;
        for (int w = 0; w < nw; w++) begin
            e = 0;
            for (int l = 0; l < 4; l++)
                if (4 * w + l < len) e[31 - 8 * l -: 8] = pay[w][31 - 8 * l -: 8];
            psum += {16'h0, e[31:16]} + {16'h0, e[15:0]};
        end
        f_psum = fold_ref(psum);
        if (force_ffff) f_psum = ~udp_fixed_sum(16'(len));
        uc = 16'h0000;
`ifdef UDP_CHECKSUM_EN
        uc = ~fold_ref({16'h0, udp_fixed_sum(16'(len))} + {16'h0, f_psum});
        if (uc == 16'h0000) uc = 16'hFFFF;
        bus.payload_sum = f_psum;
`endif
        exp_q.push_back({ul, uc});
        for (int w = 0; w < nw; w++) begin
            e = 0;
            for (int l = 0; l < 4; l++)
                if (4 * w + l < len) e[31 - 8 * l -: 8] = pay[w][31 - 8 * l -: 8];
            exp_q.push_back(e);
        end
        wr_cnt = 0; cap.delete(); fin_seen = 1'b0;
        bus.len_data = 16'(len); bus.src_ip = f_sip; bus.dest_ip = f_dip;
        bus.src_port = f_sport; bus.dest_port = f_dport; bus.identification = f_id;
        bus.type_of_ser = f_tos; bus.time_to_live = f_ttl;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("csum_busy", {31'h0, bus.busy}, 32'h1);
        check("csum_no_wr", wr_cnt, 0);
        tick();
        check("w0_latency", wr_cnt, 1);
    endtask

    // Wait for fin (bounded), optionally poking start mid-packet.
    task automatic finish_packet(input int len, input bit inject);
        for (int i = 0; i < 600 && !fin_seen; i++) begin
            tick();
            if (inject && i == 2) begin
                bus.start = 1'b1; bus.src_ip = ~f_sip; bus.len_data = 16'd4;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("fin_seen", {31'h0, fin_seen}, 32'h1);
        check("word_count", wr_cnt, 7 + (len + 3) / 4);
        check("fin_after_last", fin_cyc, last_wr_cyc + 1);
        check("sb_drained", exp_q.size(), 0);
        tick();
        check("busy_low_after", {31'h0, bus.busy}, 32'h0);
        check("fin_pulse", {31'h0, bus.fin}, 32'h0);
        repeat (3) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, bus.data_out, 32'h0);
        check({tag, "_wr"}, {31'h0, bus.wr_en}, 32'h0);
        check({tag, "_rd"}, {31'h0, bus.rd_en}, 32'h0);
        check({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
        check({tag, "_fin"}, {31'h0, bus.fin}, 32'h0);
        check({tag, "_err"}, {31'h0, bus.err}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.len_data = '0; bus.src_ip = '0; bus.dest_ip = '0;
        bus.src_port = '0; bus.dest_port = '0; bus.identification = '0;
        bus.type_of_ser = '0; bus.time_to_live = '0;
        bus.data_in = '0; bus.empty = 1'b1;
`ifdef UDP_CHECKSUM_EN
        bus.payload_sum = '0;
`endif
        cyc = 0; wr_cnt = 0; src_idx = 0; stall_cnt = 0; stall_mode = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // Golden header, 87-byte payload
        f_tos = 8'h00; f_id = 16'h0000; f_ttl = 8'h40;
        f_sip = 32'hC0A8_0001; f_dip = 32'hC0A8_00C7; f_sport = 16'd1000; f_dport = 16'd2000;
        begin_packet(87, 1'b0, 1'b0);
        finish_packet(87, 1'b0);
        if (cap.size() == 29) begin
            check("gold_w0", cap[0], 32'h4500_0073);
            check("gold_w1", cap[1], 32'h0000_4000);
            check("gold_w2", cap[2], 32'h4011_B861);
            check("gold_last_lane", {24'h0, cap[28][7:0]}, 32'h0);
        end

        // Zero-length payload
        rand_fields(); f_sport = 16'd1234; f_dport = 16'd5678;
        begin_packet(0, 1'b0, 1'b0);
        finish_packet(0, 1'b0);
`ifndef UDP_CHECKSUM_EN
        if (cap.size() == 7) check("len0_w6", cap[6], 32'h0008_0000);
`endif

        // Stalled payload source, 8 bytes
        rand_fields();
        begin_packet(8, 1'b1, 1'b0);
        finish_packet(8, 1'b0);

        // Odd lengths exercise each last-word byte mask
        for (int k = 1; k <= 3; k++) begin
            rand_fields();
            begin_packet(12 + k, k == 2, 1'b0);
            finish_packet(12 + k, 1'b0);
        end

        // Reset on the 4th header word
        rand_fields();
        begin_packet(20, 1'b0, 1'b0);
        for (int i = 0; i < 20 && wr_cnt < 4; i++) tick();
        check("reached_w3", wr_cnt, 4);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check_outputs_zero("midreset");
        reset = 1'b0;
        repeat (6) tick();
        check("no_words_after_reset", wr_cnt, 4);
        rand_fields();
        begin_packet(33, 1'b0, 1'b0);
        finish_packet(33, 1'b0);

        // Oversized length: error pulse only
        wr_cnt = 0;
        bus.len_data = 16'd65508; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("err_pulse", {31'h0, bus.err}, 32'h1);
        check("err_busy", {31'h0, bus.busy}, 32'h0);
        tick();
        check("err_one_cycle", {31'h0, bus.err}, 32'h0);
        check("err_busy2", {31'h0, bus.busy}, 32'h0);
        repeat (4) tick();
        check("err_no_wr", wr_cnt, 0);

        // Largest legal length is accepted (aborted by reset)
        bus.len_data = 16'd65507; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("max_len_no_err", {31'h0, bus.err}, 32'h0);
        check("max_len_busy", {31'h0, bus.busy}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outputs_zero("abort");
        tick();

        // start while busy is ignored
        rand_fields();
        begin_packet(10, 1'b0, 1'b0);
        finish_packet(10, 1'b1);
        check("no_queued_start", wr_cnt, 7 + 3);

`ifdef UDP_CHECKSUM_EN
        // UDP checksum that folds to all ones is sent as FFFF
        rand_fields();
        begin_packet(17, 1'b0, 1'b1);
        finish_packet(17, 1'b0);
        if (cap.size() > 6) check("udp_ffff", {16'h0, cap[6][15:0]}, 32'h0000_FFFF);
        rand_fields();
        begin_packet(41, 1'b0, 1'b0);
        finish_packet(41, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
